key_replay: RTL and testbench



---
 rtl/key_replay_pkg.sv | 17 +
 rtl/key_replay_divisor_tick.sv | 31 +++
 rtl/key_replay.sv | 216 +++++++++++++++++++++
 tb/tb_key_replay.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_replay_pkg.sv
// Shared types for the scripted key-stimulus player.
package key_replay_pkg;

   localparam int KEY_W_DEF = 5;
   localparam int DUR_W_DEF = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_e;

   typedef struct packed {
      logic [KEY_W_DEF-1:0] key;
      logic [DUR_W_DEF-1:0] dur;
   } entry_t;

endpackage

// File: rtl/key_replay_divisor_tick.sv
// Prescaler that emits a one-cycle tick every TICK_DIV clocks, restartable by clr.
module divisor_tick #(
   parameter int TICK_DIV = 27000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt_r;

   // Phase counter, wraps at TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (cnt_r == LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + PW'(1);
      end
   end

   assign tick = (cnt_r == LAST);

endmodule

// File: rtl/key_replay.sv
// Replays a stored list of (key, hold time) entries onto the game key bus,
// passing the debounced buttons through whenever no script is playing.
module key_replay
   import key_replay_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int KEY_W    = KEY_W_DEF,
   parameter int DUR_W    = DUR_W_DEF,
   parameter int TICK_DIV = 27000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [KEY_W-1:0]           wr_key,
   input  logic [DUR_W-1:0]           wr_dur,
   input  logic                       start,
   input  logic                       abort,
   input  logic [KEY_W-1:0]           key_in,
   output logic [KEY_W-1:0]           key_out,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [DUR_W-1:0] dur;
   } slot_t;

   state_e          state_r;
   state_e          state_s;
   slot_t           mem_r [DEPTH];
   slot_t           rd_data_r;
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [DUR_W-1:0] dur_r;
   logic [DUR_W-1:0] dcnt_r;
   logic [KEY_W-1:0] key_out_r;
   logic            busy_r;
   logic            done_r;

   logic            tick_s;
   logic            clr_s;
   logic            wr_en_s;
   logic            go_s;
   logic            entry_end_s;
   logic            last_s;
   logic            advance_s;
   logic            finish_s;
   logic            abort_s;
   logic [AW:0]     rd_addr_s;

   assign wr_ready = (state_r == ST_IDLE) && (count_r < CW'(DEPTH));
   assign wr_en_s  = wr_valid && wr_ready;
   assign clr_s    = (state_r != ST_PLAY) || advance_s;

   divisor_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .tick (tick_s)
   );

   // Next-state and entry sequencing decisions.
   always_comb begin
      state_s     = state_r;
      go_s        = 1'b0;
      entry_end_s = 1'b0;
      last_s      = 1'b0;
      advance_s   = 1'b0;
      finish_s    = 1'b0;
      abort_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && (count_r != '0)) begin
               go_s    = 1'b1;
               state_s = ST_PLAY;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PLAY: begin
            // A zero-duration entry ends in its first cycle.
            entry_end_s = (dur_r == '0) ||
                          (tick_s && (dcnt_r == (dur_r - DUR_W'(1))));
            last_s      = (CW'(rd_ptr_r) == (count_r - CW'(1)));
            if (abort) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
            end else if (entry_end_s && last_s) begin
               finish_s = 1'b1;
               state_s  = ST_IDLE;
            end else if (entry_end_s) begin
               advance_s = 1'b1;
               state_s   = ST_PLAY;
            end else begin
               state_s = ST_PLAY;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // rd_data_r always holds the entry to be loaded at the next entry boundary,
   // so the read address runs one entry ahead of the one about to start.
   always_comb begin
      rd_addr_s = '0;
      if (go_s) begin
         rd_addr_s = (AW+1)'(1);
      end else if (state_r == ST_PLAY) begin
         if (advance_s) begin
            rd_addr_s = {1'b0, rd_ptr_r} + (AW+1)'(2);
         end else begin
            rd_addr_s = {1'b0, rd_ptr_r} + (AW+1)'(1);
         end
      end else begin
         rd_addr_s = '0;
      end
   end

   // Entry storage write port.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= '{key: wr_key, dur: wr_dur};
      end
   end

   // Registered read with write-through so a fresh entry is visible at start.
   always_ff @(posedge clk) begin
      if (wr_en_s && ({1'b0, wr_ptr_r} == rd_addr_s)) begin
         rd_data_r <= '{key: wr_key, dur: wr_dur};
      end else if (rd_addr_s < (AW+1)'(DEPTH)) begin
         rd_data_r <= mem_r[rd_addr_s[AW-1:0]];
      end else begin
         rd_data_r <= rd_data_r;
      end
   end

   // Write pointer and entry count; the script is consumed by playback.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r  <= '0;
         wr_ptr_r <= '0;
      end else if (abort_s || finish_s) begin
         count_r  <= '0;
         wr_ptr_r <= '0;
      end else if (wr_en_s) begin
         count_r  <= count_r + CW'(1);
         wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
         count_r  <= count_r;
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Current entry, tick counter and the key bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r  <= '0;
         dur_r     <= '0;
         dcnt_r    <= '0;
         key_out_r <= '0;
      end else if (abort_s || finish_s) begin
         rd_ptr_r  <= '0;
         dcnt_r    <= '0;
         key_out_r <= key_in;
      end else if (go_s) begin
         rd_ptr_r  <= '0;
         dur_r     <= rd_data_r.dur;
         dcnt_r    <= '0;
         key_out_r <= rd_data_r.key;
      end else if (advance_s) begin
         rd_ptr_r  <= rd_ptr_r + AW'(1);
         dur_r     <= rd_data_r.dur;
         dcnt_r    <= '0;
         key_out_r <= rd_data_r.key;
      end else if (state_r == ST_PLAY) begin
         if (tick_s) begin
            dcnt_r <= dcnt_r + DUR_W'(1);
         end else begin
            dcnt_r <= dcnt_r;
         end
         key_out_r <= key_out_r;
      end else begin
         key_out_r <= key_in;
      end
   end

   // State register and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == ST_PLAY);
         done_r  <= finish_s;
      end
   end

   assign key_out = key_out_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign count   = count_r;

endmodule

// File: tb/tb_key_replay.sv
// Directed bench for key_replay with a cycle-countdown reference model.
module tb_key_replay;
   import key_replay_pkg::*;

   localparam int DEPTH    = 4;
   localparam int KEY_W    = 5;
   localparam int DUR_W    = 16;
   localparam int TICK_DIV = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_valid;
   logic             wr_ready;
   logic [KEY_W-1:0] wr_key;
   logic [DUR_W-1:0] wr_dur;
   logic             start;
   logic             abort;
   logic [KEY_W-1:0] key_in;
   logic [KEY_W-1:0] key_out;
   logic             busy;
   logic             done;
   logic [2:0]       count;

   int n_err = 0;
   int n_chk = 0;

   key_replay #(
      .DEPTH    (DEPTH),
      .KEY_W    (KEY_W),
      .DUR_W    (DUR_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_key   (wr_key),
      .wr_dur   (wr_dur),
      .start    (start),
      .abort    (abort),
      .key_in   (key_in),
      .key_out  (key_out),
      .busy     (busy),
      .done     (done),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: script queue plus remaining-cycles countdown.
   entry_t m_q[$];
   entry_t m_e;
   logic   m_play = 1'b0;
   logic   m_done = 1'b0;
   logic [KEY_W-1:0] m_key = '0;
   int     m_idx = 0;
   int     m_rem = 0;
   logic   chk_en = 1'b0;
   logic   m_go;

   function automatic int hold_cycles(input logic [DUR_W-1:0] d);
      return (d == '0) ? 1 : int'(d) * TICK_DIV;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_play = 1'b0;
         m_done = 1'b0;
         m_key  = '0;
         m_idx  = 0;
         m_rem  = 0;
         m_q.delete();
         chk_en = 1'b1;
      end else begin
         m_done = 1'b0;
         if (!m_play) begin
            m_go  = start && (m_q.size() > 0);
            if (wr_valid && (m_q.size() < DEPTH)) begin
               m_e.key = wr_key;
               m_e.dur = wr_dur;
               m_q.push_back(m_e);
            end
            m_key = key_in;
            if (m_go) begin
               m_play = 1'b1;
               m_idx  = 0;
               m_rem  = hold_cycles(m_q[0].dur);
               m_key  = m_q[0].key;
            end
         end else if (abort) begin
            m_play = 1'b0;
            m_q.delete();
            m_key  = key_in;
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_idx++;
               if (m_idx == m_q.size()) begin
                  m_play = 1'b0;
                  m_done = 1'b1;
                  m_q.delete();
                  m_key  = key_in;
               end else begin
                  m_rem = hold_cycles(m_q[m_idx].dur);
                  m_key = m_q[m_idx].key;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_key_out", 32'(key_out), 32'(m_key));
         check("model_busy", 32'(busy), 32'(m_play));
         check("model_done", 32'(done), 32'(m_done));
         check("model_count", 32'(count), 32'(m_q.size()));
         check("model_wr_ready", 32'(wr_ready), 32'((!m_play) && (m_q.size() < DEPTH)));
      end
   end

   task automatic write_entry(input logic [KEY_W-1:0] k, input logic [DUR_W-1:0] d);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_key   = k;
      wr_dur   = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_len(input logic [KEY_W-1:0] k, output int n);
      n = 0;
      while ((key_out === k) && (n < 200)) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_key   = '0;
      wr_dur   = '0;
      start    = 1'b0;
      abort    = 1'b0;
      key_in   = '0;
      @(negedge clk);
      check("reset_key_out", 32'(key_out), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_count", 32'(count), 32'h0);
      check("reset_wr_ready", 32'(wr_ready), 32'h1);
      rst = 1'b0;

      // Passthrough
      key_in = 5'b01010;
      @(negedge clk);
      check("pass_key_out", 32'(key_out), 32'h0a);
      check("pass_busy", 32'(busy), 32'h0);

      // Basic replay
      key_in = 5'b00111;
      write_entry(5'b00001, 16'd2);
      write_entry(5'b10000, 16'd1);
      check("basic_count", 32'(count), 32'h2);
      pulse_start();
      run_len(5'b00001, n);
      check("basic_len0", 32'(n), 32'd8);
      run_len(5'b10000, n);
      check("basic_len1", 32'(n), 32'd4);
      check("basic_done", 32'(done), 32'h1);
      check("basic_count_clr", 32'(count), 32'h0);
      check("basic_pass", 32'(key_out), 32'h07);
      @(negedge clk);
      check("basic_done_pulse", 32'(done), 32'h0);

      // Full, with zero-duration entries
      key_in = 5'b00000;
      write_entry(5'b00011, 16'd1);
      write_entry(5'b11111, 16'd0);
      write_entry(5'b00101, 16'd1);
      write_entry(5'b01000, 16'd0);
      check("full_wr_ready", 32'(wr_ready), 32'h0);
      check("full_count", 32'(count), 32'h4);
      write_entry(5'b10001, 16'd1);
      check("full_drop_count", 32'(count), 32'h4);
      pulse_start();
      run_len(5'b00011, n);
      check("full_len0", 32'(n), 32'd4);
      run_len(5'b11111, n);
      check("zero_dur_len", 32'(n), 32'd1);
      run_len(5'b00101, n);
      check("full_len2", 32'(n), 32'd4);
      run_len(5'b01000, n);
      check("zero_dur_last", 32'(n), 32'd1);
      check("full_done", 32'(done), 32'h1);

      // Abort
      key_in = 5'b10101;
      write_entry(5'b00110, 16'd3);
      pulse_start();
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_key_out", 32'(key_out), 32'h15);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_count", 32'(count), 32'h0);
      check("abort_no_done", 32'(done), 32'h0);
      repeat (3) @(negedge clk);

      // Ignored inputs
      pulse_start();
      check("start_empty_busy", 32'(busy), 32'h0);
      key_in = 5'b11000;
      write_entry(5'b01100, 16'd2);
      write_entry(5'b00011, 16'd1);
      pulse_start();
      wr_valid = 1'b1;
      wr_key   = 5'b11111;
      wr_dur   = 16'd5;
      start    = 1'b1;
      run_len(5'b01100, n);
      check("ign_len0", 32'(n), 32'd8);
      check("ign_count", 32'(count), 32'h2);
      run_len(5'b00011, n);
      check("ign_len1", 32'(n), 32'd4);
      wr_valid = 1'b0;
      start    = 1'b0;
      check("ign_done", 32'(done), 32'h1);
      check("ign_count_clr", 32'(count), 32'h0);

      // Reset mid-play
      key_in = 5'b01111;
      write_entry(5'b00010, 16'd3);
      pulse_start();
      repeat (4) @(negedge clk);
      check("rst_pre_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_key_out", 32'(key_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_wr_ready", 32'(wr_ready), 32'h1);
      @(negedge clk);
      check("rst_pass", 32'(key_out), 32'h0f);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
